// File: rtl/riscv_fetch_queue_pkg.sv
// Shared definitions for the prefetching instruction-fetch front end.
package riscv_fetch_queue_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    FQ_RUN   = 2'd0,
    FQ_FAULT = 2'd1,
    FQ_HALT  = 2'd2
  } fq_state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & INSTR_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue signal bundle: instruction memory bus, redirect and decode handshake.
interface riscv_fetch_queue_if
  import riscv_fetch_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_fault;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/riscv_fetch_queue_checker.sv
// Bookkeeping and bus-protocol properties for the fetch queue.
module riscv_fetch_queue_checker #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clock,
  input logic          reset,
  input logic          imem_rvalid,
  input logic          pc_push,
  input logic          pc_full,
  input logic          pc_empty,
  input logic [CW-1:0] occupancy,
  input logic [CW-1:0] live_out,
  input logic [CW-1:0] drop_cnt,
  input logic [CW-1:0] pc_count
);
  a_xlen: assert property (@(posedge clock) XLEN == 32);
  a_budget: assert property (@(posedge clock) disable iff (reset)
    ({1'b0, occupancy} + {1'b0, live_out} + {1'b0, drop_cnt}) <= (CW + 1)'(DEPTH));
  a_rvalid_expected: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid |-> ((live_out != '0) || (drop_cnt != '0)));
  a_pc_track: assert property (@(posedge clock) disable iff (reset)
    (pc_count == live_out) && (pc_empty == (live_out == '0)));
  a_pc_overflow: assert property (@(posedge clock) disable iff (reset) !(pc_push && pc_full));
endmodule

// File: rtl/riscv_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage (no bypass).
module riscv_sync_fifo
  import riscv_fetch_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign head_data = mem_r[rd_ptr_r[AW-1:0]];

  // Qualify requests; a full FIFO still accepts a push when it pops the same cycle.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage and pointer update; flush wins over push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + (AW + 1)'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW + 1)'(1'b1);
      end
    end
  end
endmodule

// File: rtl/riscv_fetch_queue.sv
// Prefetching instruction-fetch front end: in-order multi-outstanding fetch,
// handshaked delivery to decode, redirect flush and misaligned-target faults.
module riscv_fetch_queue
  import riscv_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input logic                 clock,
  input logic                 reset,
  riscv_fetch_queue_if.master bus
);
  localparam int        CW      = $clog2(DEPTH) + 1;
  localparam int        DW      = 2 * XLEN + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fq_state_e       state_r;
  fq_state_e       state_next_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [CW-1:0]   live_out_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   occupancy_s;
  logic [CW-1:0]   pc_count_s;
  logic [CW:0]     in_use_s;
  logic            imem_req_s;
  logic            fault_push_s;
  logic            grant_s;
  logic            rsp_drop_s;
  logic            rsp_live_s;
  logic            rsp_any_s;
  logic            pc_pop_s;
  logic            pc_full_s;
  logic            pc_empty_s;
  logic [XLEN-1:0] pc_head_s;
  logic            data_push_s;
  logic            data_pop_s;
  logic            data_full_s;
  logic            data_empty_s;
  logic [DW-1:0]   data_in_s;
  logic [DW-1:0]   data_head_s;

  // Classify the response and total the slots already committed.
  always_comb begin
    in_use_s   = {1'b0, occupancy_s} + {1'b0, live_out_r} + {1'b0, drop_cnt_r};
    rsp_drop_s = bus.imem_rvalid && (drop_cnt_r != '0);
    rsp_live_s = bus.imem_rvalid && (drop_cnt_r == '0) && (live_out_r != '0);
    rsp_any_s  = rsp_drop_s || rsp_live_s;
  end

  assign grant_s     = imem_req_s && bus.imem_gnt;
  assign pc_pop_s    = rsp_live_s && !bus.redirect_valid;
  assign data_push_s = !bus.redirect_valid && (rsp_live_s || fault_push_s);
  assign data_pop_s  = bus.if_ready && !bus.redirect_valid;
  assign data_in_s   = fault_push_s ? {{XLEN{1'b0}}, fetch_pc_r, 1'b1}
                                    : {bus.imem_rdata, pc_head_s, 1'b0};

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= FQ_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a redirect is taken from any state.
  always_comb begin
    state_next_s = state_r;
    if (bus.redirect_valid) begin
      state_next_s = is_misaligned(bus.redirect_pc[1:0]) ? FQ_FAULT : FQ_RUN;
    end else begin
      case (state_r)
        FQ_RUN:   state_next_s = FQ_RUN;
        FQ_FAULT: state_next_s = fault_push_s ? FQ_HALT : FQ_FAULT;
        FQ_HALT:  state_next_s = FQ_HALT;
        default:  state_next_s = FQ_RUN;
      endcase
    end
  end

  // FSM outputs: fetch request and fault-entry insertion.
  always_comb begin
    imem_req_s   = 1'b0;
    fault_push_s = 1'b0;
    if (!reset && !bus.redirect_valid) begin
      case (state_r)
        FQ_RUN:   imem_req_s = (in_use_s < DEPTH_C);
        FQ_FAULT: fault_push_s = (drop_cnt_r == '0) && !data_full_s;
        FQ_HALT:  imem_req_s = 1'b0;
        default:  imem_req_s = 1'b0;
      endcase
    end else begin
      imem_req_s = 1'b0;
    end
  end

  // Fetch address and outstanding-request accounting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      live_out_r <= '0;
      drop_cnt_r <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= bus.redirect_pc;
      live_out_r <= '0;
      // Whatever response lands now answers an old request, dropped or live.
      drop_cnt_r <= drop_cnt_r + live_out_r - CW'(rsp_any_s);
    end else begin
      fetch_pc_r <= grant_s ? fetch_pc_r + XLEN'(3'd4) : fetch_pc_r;
      live_out_r <= live_out_r + CW'(grant_s) - CW'(rsp_live_s);
      drop_cnt_r <= drop_cnt_r - CW'(rsp_drop_s);
    end
  end

  riscv_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clock(clock), .reset(reset), .push(grant_s), .pop(pc_pop_s),
    .flush(bus.redirect_valid), .push_data(fetch_pc_r), .full(pc_full_s),
    .empty(pc_empty_s), .count(pc_count_s), .head_data(pc_head_s)
  );

  riscv_sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_data_fifo (
    .clock(clock), .reset(reset), .push(data_push_s), .pop(data_pop_s),
    .flush(bus.redirect_valid), .push_data(data_in_s), .full(data_full_s),
    .empty(data_empty_s), .count(occupancy_s), .head_data(data_head_s)
  );

  riscv_fetch_queue_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) u_checker (
    .clock(clock), .reset(reset), .imem_rvalid(bus.imem_rvalid), .pc_push(grant_s),
    .pc_full(pc_full_s), .pc_empty(pc_empty_s), .occupancy(occupancy_s),
    .live_out(live_out_r), .drop_cnt(drop_cnt_r), .pc_count(pc_count_s)
  );

  assign bus.imem_req  = imem_req_s;
  assign bus.imem_addr = fetch_pc_r;
  assign bus.if_valid  = !data_empty_s;
  assign bus.if_instr  = data_head_s[DW-1 -: XLEN];
  assign bus.if_pc     = data_head_s[XLEN:1];
  assign bus.if_fault  = data_head_s[0];
endmodule
